// File: rtl/i2s_pkg.sv
// Shared constants and state type for the I2S / left-justified receiver.
package i2s_pkg;
    localparam logic I2S_STD = 1'b0;
    localparam logic I2S_LJ  = 1'b1;

    typedef enum logic {UNSYNC, SYNC} rx_state_e;
endpackage

// File: rtl/i2s_sync_deb.sv
// Two-flop synchroniser plus agreement debounce for one asynchronous pin.
module i2s_sync_deb (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic level
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;
    logic level_q, level_d;

    always_comb begin
        meta_d  = pin;
        sync_d  = meta_q;
        prev_d  = sync_q;
        // a single-cycle excursion never produces two agreeing samples
        level_d = (sync_q == prev_q) ? sync_q : level_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
            level_q <= 1'b0;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;
endmodule

// File: rtl/i2s_rx.sv
// I2S / left-justified receiver: pin conditioning, deserialiser, word sync,
// lost-clock detection and paired sample output.
//
// state  | meaning
// UNSYNC | no word boundary seen since reset/timeout/mode change; nothing committed
// SYNC   | aligned to word boundaries; each boundary commits the finished word
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    mode,
    input  logic                    bclk,
    input  logic                    ws,
    input  logic                    sd,
    output logic signed [WIDTH-1:0] left,
    output logic signed [WIDTH-1:0] right,
    output logic                    valid,
    output logic                    clk_ok
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [WIDTH-1:0] MSB_BIT = {1'b1, {(WIDTH-1){1'b0}}};

    logic bclk_s, ws_s, sd_s;

    i2s_sync_deb u_deb_bclk (.clk(clk), .reset_n(reset_n), .pin(bclk), .level(bclk_s));
    i2s_sync_deb u_deb_ws   (.clk(clk), .reset_n(reset_n), .pin(ws),   .level(ws_s));
    i2s_sync_deb u_deb_sd   (.clk(clk), .reset_n(reset_n), .pin(sd),   .level(sd_s));

    rx_state_e        state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [WIDTH-1:0] left_q, left_d;
    logic [WIDTH-1:0] right_q, right_d;
    logic             valid_q, valid_d;
    logic             pair_q, pair_d;
    logic             ws_last_q, ws_last_d;
    logic             bclk_prev_q, bclk_prev_d;
    logic             mode_q, mode_d;

    logic             bit_ev;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] commit_val;

    assign bit_ev = bclk_s & ~bclk_prev_q;

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        left_d      = left_q;
        right_d     = right_q;
        valid_d     = 1'b0;
        pair_d      = pair_q;
        ws_last_d   = ws_last_q;
        bclk_prev_d = bclk_s;
        mode_d      = mode;

        // bits past WIDTH fall off the end; short words keep zero LSBs
        bit_mask   = (cnt_q < CW'(WIDTH)) ? (MSB_BIT >> cnt_q) : '0;
        word       = sh_q | (sd_s ? bit_mask : '0);
        commit_val = (mode == I2S_STD) ? word : sh_q;

        if (bit_ev) begin
            tmo_d     = '0;
            ws_last_d = ws_s;
            if (ws_s != ws_last_q) begin
                if (state_q == SYNC) begin
                    if (ws_last_q == 1'b0) begin
                        left_d = commit_val;
                        pair_d = 1'b1;
                    end else begin
                        right_d = commit_val;
                        valid_d = pair_q;
                        pair_d  = 1'b0;
                    end
                end else begin
                    state_d = SYNC;
                    pair_d  = 1'b0;
                end
                if (mode == I2S_STD) begin
                    sh_d  = '0;
                    cnt_d = '0;
                end else begin
                    sh_d  = sd_s ? MSB_BIT : '0;
                    cnt_d = CW'(1);
                end
            end else begin
                sh_d = word;
                if (cnt_q < CW'(WIDTH)) cnt_d = cnt_q + CW'(1);
            end
        end else if (tmo_q >= TW'(TIMEOUT - 1)) begin
            tmo_d   = TW'(TIMEOUT);
            state_d = UNSYNC;
            left_d  = '0;
            right_d = '0;
            pair_d  = 1'b0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        if (mode != mode_q) begin
            state_d = UNSYNC;
            pair_d  = 1'b0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= UNSYNC;
            sh_q        <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
            pair_q      <= 1'b0;
            ws_last_q   <= 1'b0;
            bclk_prev_q <= 1'b0;
            mode_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            left_q      <= left_d;
            right_q     <= right_d;
            valid_q     <= valid_d;
            pair_q      <= pair_d;
            ws_last_q   <= ws_last_d;
            bclk_prev_q <= bclk_prev_d;
            mode_q      <= mode_d;
        end
    end

    assign left   = left_q;
    assign right  = right_q;
    assign valid  = valid_q;
    assign clk_ok = (state_q == SYNC);
endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: spec-example table, random frames against a
// slot-level reference model, and hand-written timeout/reset/mode/glitch cases.
module tb_i2s_rx;
    localparam int W   = 16;
    localparam int TMO = 255;

    logic clk = 1'b0;
    logic reset_n, mode, bclk, ws, sd;
    logic signed [W-1:0] left, right;
    logic valid, clk_ok;

    always #5 clk = ~clk;

    i2s_rx #(.WIDTH(W), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .mode(mode), .bclk(bclk), .ws(ws), .sd(sd),
        .left(left), .right(right), .valid(valid), .clk_ok(clk_ok)
    );

    int checks   = 0;
    int failures = 0;

    logic wlj[$];
    logic txw[$];
    logic dq[$];
    logic [W-1:0] obs_l[$], obs_r[$], exp_l[$], exp_r[$];
    logic last_ws = 1'b0;

    logic valid_d1 = 1'b0;
    int   dbl = 0;

    always @(negedge clk) begin
        if (valid) begin
            obs_l.push_back(left);
            obs_r.push_back(right);
        end
        if (valid && valid_d1) dbl <= dbl + 1;
        valid_d1 <= valid;
    end

    typedef struct {
        bit          m;
        bit          i2s_t;
        int          len;
        logic [63:0] lv;
        logic [63:0] rv;
        logic [W-1:0] el;
        logic [W-1:0] er;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_slot(input logic w, input int len, input logic [63:0] val);
        for (int j = 0; j < len; j++) begin
            wlj.push_back(w);
            dq.push_back(val[len-1-j]);
        end
    endtask

    // I2S timing moves every ws transition one bit earlier than the data
    task automatic finalize(input bit i2s_t);
        txw.delete();
        for (int i = 0; i < wlj.size(); i++)
            txw.push_back((i2s_t && (i + 1 < wlj.size())) ? wlj[i+1] : wlj[i]);
    endtask

    task automatic build(input bit i2s_t, input int nfr, input int len,
                         input logic [63:0] lv, input logic [63:0] rv,
                         input bit rnd, input int tail);
        wlj.delete();
        dq.delete();
        add_slot(1'b0, 3, 64'($urandom));
        add_slot(1'b1, 2 + int'($urandom_range(0, 5)), 64'($urandom));
        for (int f = 0; f < nfr; f++) begin
            int ll, rl;
            logic [63:0] a, b;
            ll = len; rl = len; a = lv; b = rv;
            if (rnd) begin
                ll = int'($urandom_range(4, 40));
                rl = int'($urandom_range(4, 40));
                a  = {$urandom, $urandom};
                b  = {$urandom, $urandom};
            end
            add_slot(1'b0, ll, a);
            add_slot(1'b1, rl, b);
        end
        add_slot(1'b0, tail, 64'($urandom));
        finalize(i2s_t);
    endtask

    task automatic send_bit(input logic w, input logic d, input bit g);
        @(negedge clk); bclk = 1'b0; ws = w; sd = d;
        @(negedge clk); if (g) bclk = 1'b1;
        @(negedge clk); bclk = 1'b0;
        @(negedge clk);
        @(negedge clk); bclk = 1'b1;
        @(negedge clk); if (g) ws = ~w;
        @(negedge clk); ws = w;
        @(negedge clk);
    endtask

    task automatic send_stream(input bit g);
        for (int i = 0; i < txw.size(); i++) send_bit(txw[i], dq[i], g);
        last_ws = txw[txw.size()-1];
    endtask

    // Slot-level model: words run between ws transitions; mode 0 words end
    // on the transition bit, mode 1 words begin on it. First transition only syncs.
    task automatic model(input bit m, input logic prev);
        int b[$];
        logic p;
        logic pair;
        logic [W-1:0] pl, v;
        exp_l.delete();
        exp_r.delete();
        p = prev;
        for (int i = 0; i < txw.size(); i++) begin
            if (txw[i] != p) b.push_back(i);
            p = txw[i];
        end
        pair = 1'b0;
        pl   = '0;
        for (int k = 1; k < b.size(); k++) begin
            int st, sp;
            st = m ? b[k-1] : b[k-1] + 1;
            sp = m ? b[k] - 1 : b[k];
            v  = '0;
            for (int j = 0; (j <= sp - st) && (j < W); j++) v[W-1-j] = dq[st+j];
            if (txw[b[k-1]] == 1'b0) begin
                pl   = v;
                pair = 1'b1;
            end else if (pair) begin
                exp_l.push_back(pl);
                exp_r.push_back(v);
                pair = 1'b0;
            end
        end
    endtask

    task automatic compare_pairs(input string tag);
        repeat (20) @(negedge clk);
        check({tag, "_count"}, 64'(obs_l.size()), 64'(exp_l.size()));
        for (int i = 0; i < exp_l.size() && i < obs_l.size(); i++) begin
            check({tag, "_left"},  64'(obs_l[i]), 64'(exp_l[i]));
            check({tag, "_right"}, 64'(obs_r[i]), 64'(exp_r[i]));
        end
        obs_l.delete();
        obs_r.delete();
    endtask

    task automatic do_reset();
        bclk = 1'b0; ws = 1'b0; sd = 1'b0;
        repeat (8) @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        last_ws = 1'b0;
        obs_l.delete();
        obs_r.delete();
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b1, 32, 64'h12345678, 64'hABCDEF01, 16'h1234, 16'hABCD};
        tbl[1] = '{1'b1, 1'b0, 32, 64'h12345678, 64'hABCDEF01, 16'h1234, 16'hABCD};
        tbl[2] = '{1'b0, 1'b0, 32, 64'h12340000, 64'hABCD0000, 16'h2468, 16'h579A};
        tbl[3] = '{1'b0, 1'b1, 24, 64'h123456,   64'h654321,   16'h1234, 16'h6543};
        tbl[4] = '{1'b0, 1'b1, 8,  64'hA5,       64'h5A,       16'hA500, 16'h5A00};
        tbl[5] = '{1'b1, 1'b0, 8,  64'h80,       64'h7F,       16'h8000, 16'h7F00};

        mode = 1'b0; bclk = 1'b0; ws = 1'b0; sd = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_left",   64'($unsigned(left)),  64'(0));
        check("rst_right",  64'($unsigned(right)), 64'(0));
        check("rst_valid",  64'(valid),  64'(0));
        check("rst_clk_ok", 64'(clk_ok), 64'(0));
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // pin edge to registered sync: 4 cycles to the bit event, then 1 more
        repeat (3) send_bit(1'b0, 1'b0, 1'b0);
        @(negedge clk); bclk = 1'b0; ws = 1'b1; sd = 1'b0;
        repeat (4) @(negedge clk);
        bclk = 1'b1;
        repeat (4) @(negedge clk);
        check("lat_clk_ok_early", 64'(clk_ok), 64'(0));
        @(negedge clk);
        check("lat_clk_ok", 64'(clk_ok), 64'(1));

        for (int r = 0; r < 6; r++) begin
            mode = tbl[r].m;
            do_reset();
            build(tbl[r].i2s_t, 2, tbl[r].len, tbl[r].lv, tbl[r].rv, 1'b0, 4);
            send_stream(1'b0);
            repeat (20) @(negedge clk);
            check($sformatf("tbl%0d_valids", r), 64'(obs_l.size()), 64'(2));
            check($sformatf("tbl%0d_left", r),   64'($unsigned(left)),  64'(tbl[r].el));
            check($sformatf("tbl%0d_right", r),  64'($unsigned(right)), 64'(tbl[r].er));
            check($sformatf("tbl%0d_clk_ok", r), 64'(clk_ok), 64'(1));
            obs_l.delete();
            obs_r.delete();
        end

        for (int r = 0; r < 8; r++) begin
            bit m, t;
            m = 1'($urandom_range(0, 1));
            t = ($urandom_range(0, 3) == 0) ? m : ~m;
            mode = m;
            do_reset();
            build(t, 2, 0, '0, '0, 1'b1, 4);
            send_stream(1'b0);
            model(m, 1'b0);
            compare_pairs($sformatf("rnd%0d", r));
        end

        // lost bit clock, then recovery
        mode = 1'b0;
        do_reset();
        build(1'b1, 2, 0, '0, '0, 1'b1, 4);
        send_stream(1'b0);
        model(1'b0, 1'b0);
        compare_pairs("tmo_pre");
        repeat (200) @(negedge clk);
        check("tmo_clk_ok_held", 64'(clk_ok), 64'(1));
        repeat (100) @(negedge clk);
        check("tmo_clk_ok", 64'(clk_ok), 64'(0));
        check("tmo_left",   64'($unsigned(left)),  64'(0));
        check("tmo_right",  64'($unsigned(right)), 64'(0));
        build(1'b1, 2, 0, '0, '0, 1'b1, 4);
        send_stream(1'b0);
        model(1'b0, last_ws);
        compare_pairs("tmo_resume");

        // mode change mid-frame
        mode = 1'b0;
        do_reset();
        build(1'b1, 1, 32, 64'h12345678, 64'hABCDEF01, 1'b0, 10);
        send_stream(1'b0);
        model(1'b0, 1'b0);
        compare_pairs("mchg_pre");
        check("mchg_clk_ok_before", 64'(clk_ok), 64'(1));
        @(negedge clk); mode = 1'b1;
        repeat (3) @(negedge clk);
        check("mchg_clk_ok", 64'(clk_ok), 64'(0));
        build(1'b0, 2, 0, '0, '0, 1'b1, 4);
        send_stream(1'b0);
        model(1'b1, last_ws);
        compare_pairs("mchg_post");

        // reset mid-word
        mode = 1'b0;
        do_reset();
        build(1'b1, 1, 32, 64'h12345678, 64'hABCDEF01, 1'b0, 10);
        send_stream(1'b0);
        model(1'b0, 1'b0);
        compare_pairs("mrst_pre");
        bclk = 1'b0; ws = 1'b0;
        repeat (8) @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("mrst_left",   64'($unsigned(left)),  64'(0));
        check("mrst_right",  64'($unsigned(right)), 64'(0));
        check("mrst_valid",  64'(valid),  64'(0));
        check("mrst_clk_ok", 64'(clk_ok), 64'(0));
        reset_n = 1'b1;
        last_ws = 1'b0;
        repeat (2) @(negedge clk);
        build(1'b1, 2, 0, '0, '0, 1'b1, 4);
        send_stream(1'b0);
        model(1'b0, 1'b0);
        compare_pairs("mrst_post");

        // single-cycle glitches on bclk and ws
        for (int r = 0; r < 2; r++) begin
            mode = 1'(r);
            do_reset();
            build(r == 0, 2, 0, '0, '0, 1'b1, 4);
            send_stream(1'b1);
            model(1'(r), 1'b0);
            compare_pairs($sformatf("glitch%0d", r));
        end

        check("valid_single_cycle", 64'(dbl), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
